// File: rtl/mon_bus_cap_sched.sv
// S1D13700 host-bus monitor capture scheduler.
// Syncs host strobes, queues bus cycles, frames them as 2 bytes for the UART.
module mon_bus_cap_sched #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mon_en,
  input  logic          ce_x,
  input  logic          a0,
  input  logic          wr_x,
  input  logic          rd_x,
  input  logic [7:0]    dat,
  output logic          tx_valid,
  output logic [7:0]    tx_data,
  input  logic          tx_ready,
  output logic [AW:0]   fifo_lvl,
  output logic [7:0]    ovf_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DAT  = 2'd2
  } state_t;

  // Sync bundle layout: {ce, a0, wr, rd, dat}; idle bus is ce/wr/rd high
  localparam logic [11:0] LP_SYNC_RST = 12'hB00;
  localparam logic [AW:0] LP_FULL     = (AW+1)'(DEPTH);

  logic [11:0]   r_s1;
  logic [11:0]   r_s2;
  logic          r_wr_s3;
  logic          r_rd_s3;
  logic [9:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_lvl;
  logic [7:0]    r_ovf;
  logic [9:0]    r_hold;
  state_t        r_st;
  state_t        w_nxt;

  logic          w_wr_rise;
  logic          w_rd_rise;
  logic          w_evt;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [9:0]    w_rec;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1    <= LP_SYNC_RST;
      r_s2    <= LP_SYNC_RST;
      r_wr_s3 <= 1'b1;
      r_rd_s3 <= 1'b1;
    end else begin
      r_s1    <= {ce_x, a0, wr_x, rd_x, dat};
      r_s2    <= r_s1;
      r_wr_s3 <= r_s2[9];
      r_rd_s3 <= r_s2[8];
    end
  end

  assign w_wr_rise = r_s2[9] & ~r_wr_s3;
  assign w_rd_rise = r_s2[8] & ~r_rd_s3;
  assign w_evt     = (w_wr_rise | w_rd_rise) & ~r_s2[11] & mon_en;
  // A simultaneous write edge wins, so rd is set only for a lone read edge
  assign w_rec     = {~w_wr_rise, r_s2[10], r_s2[7:0]};
  assign w_full    = (r_lvl == LP_FULL);
  assign w_push    = w_evt & ~w_full;

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wp] <= w_rec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_lvl  <= '0;
      r_ovf  <= 8'h00;
      r_hold <= '0;
    end else begin
      if (w_push) begin
        r_wp <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp   <= r_rp + 1'b1;
        r_hold <= r_mem[r_rp];
      end
      if (w_push && !w_pop) begin
        r_lvl <= r_lvl + 1'b1;
      end else if (!w_push && w_pop) begin
        r_lvl <= r_lvl - 1'b1;
      end
      if (w_evt && w_full && r_ovf != 8'hFF) begin
        r_ovf <= r_ovf + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st <= IDLE;
    end else begin
      r_st <= w_nxt;
    end
  end

  always_comb begin
    w_nxt    = r_st;
    w_pop    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    unique case (r_st)
      IDLE: begin
        if (r_lvl != '0) begin
          w_pop = 1'b1;
          w_nxt = HDR;
        end
      end
      HDR: begin
        tx_valid = 1'b1;
        tx_data  = {4'hA, 2'b00, r_hold[9], r_hold[8]};
        if (tx_ready) begin
          w_nxt = DAT;
        end
      end
      DAT: begin
        tx_valid = 1'b1;
        tx_data  = r_hold[7:0];
        if (tx_ready) begin
          w_nxt = IDLE;
        end
      end
      default: begin
        w_nxt = IDLE;
      end
    endcase
  end

  assign fifo_lvl = r_lvl;
  assign ovf_cnt  = r_ovf;

endmodule

// File: tb/tb_mon_bus_cap_sched.sv
// Bench for mon_bus_cap_sched: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_mon_bus_cap_sched;

  logic       clk;
  logic       rst;
  logic       mon_en;
  logic       ce_x;
  logic       a0;
  logic       wr_x;
  logic       rd_x;
  logic [7:0] dat;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic [4:0] fifo_lvl;
  logic [7:0] ovf_cnt;

  mon_bus_cap_sched #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .mon_en(mon_en),
    .ce_x(ce_x), .a0(a0), .wr_x(wr_x), .rd_x(rd_x), .dat(dat),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .fifo_lvl(fifo_lvl), .ovf_cnt(ovf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  typedef struct packed {
    logic       ce;
    logic       a0;
    logic       wr;
    logic       rd;
    logic [7:0] d;
  } pins_t;

  localparam pins_t PIN_IDLE = '{ce: 1'b1, a0: 1'b0, wr: 1'b1, rd: 1'b1, d: 8'h00};
  localparam int DEPTH = 16;

  // Model: pins seen at the last three edges, record queue, bytes of the
  // frame currently offered, and the drop counter
  pins_t      h0, h1, h2;
  logic [9:0] m_q[$];
  logic [7:0] m_fr[$];
  int         m_ovf;
  bit         m_init = 0;
  logic [7:0] got[$];

  initial begin
    forever begin
      @(negedge clk);
      if (m_init) begin
        chk("tx_valid", tx_valid, m_fr.size() != 0);
        chk("tx_data", tx_data, m_fr.size() != 0 ? m_fr[0] : 8'h00);
        chk("fifo_lvl", fifo_lvl, m_q.size());
        chk("ovf_cnt", ovf_cnt, m_ovf);
        if (tx_valid && tx_ready) got.push_back(tx_data);
      end
      if (rst) begin
        m_q.delete();
        m_fr.delete();
        m_ovf = 0;
        h0 = PIN_IDLE;
        h1 = PIN_IDLE;
        h2 = PIN_IDLE;
        m_init = 1;
      end else begin
        bit wrr, rdr, ev, full;
        logic [9:0] rec;
        wrr  = h1.wr && !h2.wr;
        rdr  = h1.rd && !h2.rd;
        ev   = (wrr || rdr) && !h1.ce && mon_en;
        full = (m_q.size() == DEPTH);
        rec  = {!wrr, h1.a0, h1.d};
        if (m_fr.size() != 0) begin
          if (tx_ready) void'(m_fr.pop_front());
        end else if (m_q.size() != 0) begin
          logic [9:0] r;
          r = m_q.pop_front();
          m_fr.push_back({4'hA, 2'b00, r[9], r[8]});
          m_fr.push_back(r[7:0]);
        end
        if (ev) begin
          if (full) begin
            if (m_ovf < 255) m_ovf++;
          end else begin
            m_q.push_back(rec);
          end
        end
        h2 = h1;
        h1 = h0;
        h0 = '{ce: ce_x, a0: a0, wr: wr_x, rd: rd_x, d: dat};
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  task automatic bus_cyc(input bit rd, input bit a, input logic [7:0] d);
    ce_x = 1'b0;
    a0   = a;
    dat  = d;
    if (rd) rd_x = 1'b0;
    else    wr_x = 1'b0;
    settle(2);
    rd_x = 1'b1;
    wr_x = 1'b1;
    settle(2);
  endtask

  task automatic wait_bytes(input int n, input string nm);
    int k;
    k = 0;
    while (got.size() < n && k < 500) begin
      tick();
      k++;
    end
    chk(nm, got.size(), n);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    settle(2);
    rst = 1'b0;
  endtask

  initial begin
    int cnt;
    bit seen;
    rst = 1'b1; mon_en = 1'b1; tx_ready = 1'b0;
    ce_x = 1'b1; a0 = 1'b0; wr_x = 1'b1; rd_x = 1'b1; dat = 8'h00;
    settle(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", tx_valid, 0);
    chk("rst_data", tx_data, 8'h00);
    chk("rst_lvl", fifo_lvl, 0);
    chk("rst_ovf", ovf_cnt, 0);

    // Write a0=1 0x40, strobe rise to tx_valid latency
    tick();
    tx_ready = 1'b1; ce_x = 1'b0; a0 = 1'b1; dat = 8'h40; wr_x = 1'b0;
    settle(3);
    got.delete();
    wr_x = 1'b1;
    cnt = 0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      cnt++;
      if (tx_valid) seen = 1;
    end
    chk("t1_latency", cnt, 5);
    tick();
    wait_bytes(2, "t1_count");
    chk("t1_hdr", got[0], 8'hA1);
    chk("t1_dat", got[1], 8'h40);

    // Read a0=0 0x5C, then same read with chip deselected
    got.delete();
    bus_cyc(1, 0, 8'h5C);
    wait_bytes(2, "t2_count");
    chk("t2_hdr", got[0], 8'hA2);
    chk("t2_dat", got[1], 8'h5C);
    settle(4);
    ce_x = 1'b1; rd_x = 1'b0;
    settle(2);
    rd_x = 1'b1;
    settle(4);
    @(negedge clk);
    chk("t2_ce_lvl", fifo_lvl, 0);
    chk("t2_ce_valid", tx_valid, 0);

    // Fill: first record sits in the hold register, next 16 fill the FIFO
    tick();
    tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) bus_cyc(0, 0, 8'(i));
    settle(3);
    @(negedge clk);
    chk("t3_lvl_full", fifo_lvl, 16);
    tick();
    for (int i = 0; i < 3; i++) bus_cyc(0, 0, 8'hEE);
    settle(3);
    @(negedge clk);
    chk("t3_ovf", ovf_cnt, 3);
    tick();
    got.delete();
    tx_ready = 1'b1;
    wait_bytes(34, "t3_count");
    settle(5);
    chk("t3_final_count", got.size(), 34);
    for (int k = 0; k < 17; k++) begin
      chk("t3_hdr", got[2*k], 8'hA0);
      chk("t3_dat", got[2*k+1], 8'(k));
    end

    // Overflow saturation
    tx_ready = 1'b0;
    for (int i = 0; i < 300; i++) bus_cyc(0, i[0], 8'(i));
    settle(3);
    @(negedge clk);
    chk("t4_ovf_sat", ovf_cnt, 8'hFF);
    tick();
    do_reset();

    // Stall in HDR, then reset in DAT
    tx_ready = 1'b0;
    bus_cyc(1, 1, 8'h77);
    bus_cyc(0, 0, 8'h11);
    bus_cyc(0, 1, 8'h22);
    settle(3);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("t5_hold_valid", tx_valid, 1);
      chk("t5_hold_data", tx_data, 8'hA3);
    end
    chk("t5_lvl", fifo_lvl, 2);
    tick();
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    @(negedge clk);
    chk("t5_dat", tx_data, 8'h77);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_rst_valid", tx_valid, 0);
    chk("t5_rst_lvl", fifo_lvl, 0);
    tick();

    // Capture disabled with records pending: drain continues, no new pushes
    for (int i = 0; i < 4; i++) bus_cyc(0, 1, 8'h30 + 8'(i));
    settle(3);
    @(negedge clk);
    chk("t6_lvl", fifo_lvl, 3);
    tick();
    mon_en = 1'b0;
    got.delete();
    bus_cyc(0, 0, 8'h99);
    tx_ready = 1'b1;
    bus_cyc(0, 0, 8'h98);
    settle(20);
    chk("t6_count", got.size(), 8);
    chk("t6_last", got[7], 8'h33);
    @(negedge clk);
    chk("t6_lvl_end", fifo_lvl, 0);
    tick();
    mon_en = 1'b1;

    // Random traffic against the model
    for (int seg = 0; seg < 4; seg++) begin
      int rp;
      rp = (seg == 0) ? 90 : (seg == 1) ? 10 : (seg == 2) ? 50 : 0;
      for (int c = 0; c < 1500; c++) begin
        if ($urandom_range(99) < 33) wr_x = ~wr_x;
        if ($urandom_range(99) < 25) rd_x = ~rd_x;
        ce_x     = ($urandom_range(7) == 0);
        a0       = 1'($urandom);
        dat      = 8'($urandom);
        tx_ready = ($urandom_range(99) < rp);
        mon_en   = ($urandom_range(15) != 0);
        rst      = ($urandom_range(399) == 0);
        tick();
      end
    end
    rst = 1'b0; wr_x = 1'b1; rd_x = 1'b1; ce_x = 1'b1;
    mon_en = 1'b1; tx_ready = 1'b1;
    settle(80);
    @(negedge clk);
    chk("drain_lvl", fifo_lvl, 0);
    chk("drain_valid", tx_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
